// File: rtl/mvau_wload_pkg.sv
// Shared types and helpers for the MVAU weight stream loader.
// Contents:
//   wload_state_t  - loader FSM state encoding (IDLE, LOAD, DONE)
//   pe_cnt_width() - width of the PE bank counter (at least 1 bit)
package mvau_wload_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } wload_state_t;

  // A single bank still needs a 1-bit counter so that the port stays legal.
  function automatic int pe_cnt_width(input int pe);
    return (pe > 1) ? $clog2(pe) : 1;
  endfunction

endpackage

// File: rtl/mvau_weight_bank_rw.sv
// One PE weight bank: simple dual-port RAM, DW bits x DEPTH words.
// The read is registered and read-first: a read and a write to the same
// address in one cycle return the old word.
// Ports:
//   clk    in   clock
//   rst_n  in   synchronous active-low reset (clears rdata only)
//   we     in   write enable
//   waddr  in   write address (AW bits)
//   wdata  in   write data (DW bits)
//   raddr  in   read address (AW bits)
//   rdata  out  registered read data (DW bits), 1-cycle latency
module mvau_weight_bank_rw #(
  parameter int DW    = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  (* ram_style = "auto" *) logic [DW-1:0] mem [0:DEPTH-1];

  // Addresses past the end of the bank are ignored on write and read as zero.
  logic wr_in_range;
  logic rd_in_range;
  assign wr_in_range = {1'b0, waddr} < DEPTH_W;
  assign rd_in_range = {1'b0, raddr} < DEPTH_W;

  // NOTE: the storage array has no reset so it can map onto block RAM;
  // only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we && wr_in_range) begin
      mem[waddr[IW-1:0]] <= wdata;
    end
  end

  // NOTE: non-blocking assignment samples mem before this edge's write lands,
  // which is exactly what gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= rd_in_range ? mem[raddr[IW-1:0]] : '0;
    end
  end

endmodule

// File: rtl/mvau_weight_stream_loader.sv
// Runtime-writable MVAU weight store. A weight image arrives over an
// AXI-Stream slave and is scattered PE-major across PE banks (word k goes to
// bank k mod PE, address k / PE). All banks share one registered read port.
// Ports:
//   aclk, aresetn   clock, synchronous active-low reset
//   cfg_start       pulse: begin a new load (ignored while loading)
//   s_axis_*        weight stream slave (tdata, tvalid, tready, tlast)
//   wmem_addr       read address common to all banks
//   wmem_out        read data, bank p at [p*SIMD*TW +: SIMD*TW], 1-cycle latency
//   load_done       high while the loader sits in DONE
//   weights_valid   last load completed with the correct length
//   len_err         sticky length error (tlast early or missing)
module mvau_weight_stream_loader
  import mvau_wload_pkg::*;
#(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int PE           = 2,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       cfg_start,
  input  logic [SIMD*TW-1:0]         s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [WMEM_ADDR_BW-1:0]    wmem_addr,
  output logic [PE*SIMD*TW-1:0]      wmem_out,
  output logic                       load_done,
  output logic                       weights_valid,
  output logic                       len_err
);

  localparam int DW  = SIMD * TW;
  localparam int PCW = pe_cnt_width(PE);

  wload_state_t            state;
  logic [PCW-1:0]          pe_cnt;
  logic [WMEM_ADDR_BW-1:0] addr_cnt;
  logic                    hs;
  logic                    final_word;
  logic                    good_end;
  logic [PE-1:0]           bank_we;

  assign hs         = s_axis_tvalid & s_axis_tready;
  assign final_word = (addr_cnt == WMEM_ADDR_BW'(WMEM_DEPTH - 1)) &&
                      (pe_cnt == PCW'(PE - 1));
  assign good_end   = final_word & s_axis_tlast;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    bank_we = '0;
    for (int p = 0; p < PE; p++) begin
      bank_we[p] = hs && (pe_cnt == PCW'(p));
    end
  end

  // Loader FSM; tready and the status flags are registered with the state.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= IDLE;
      pe_cnt        <= '0;
      addr_cnt      <= '0;
      s_axis_tready <= 1'b0;
      load_done     <= 1'b0;
      weights_valid <= 1'b0;
      len_err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (cfg_start) begin
            state         <= LOAD;
            pe_cnt        <= '0;
            addr_cnt      <= '0;
            s_axis_tready <= 1'b1;
            load_done     <= 1'b0;
            weights_valid <= 1'b0;
            len_err       <= 1'b0;
          end
        end
        LOAD: begin
          if (hs) begin
            if (final_word || s_axis_tlast) begin
              // Counters freeze here; surplus words stay stalled upstream.
              state         <= DONE;
              s_axis_tready <= 1'b0;
              load_done     <= 1'b1;
              weights_valid <= good_end;
              len_err       <= ~good_end;
            end else if (pe_cnt == PCW'(PE - 1)) begin
              pe_cnt   <= '0;
              addr_cnt <= addr_cnt + 1'b1;
            end else begin
              pe_cnt <= pe_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < PE; p++) begin : g_bank
    mvau_weight_bank_rw #(
      .DW    (DW),
      .DEPTH (WMEM_DEPTH),
      .AW    (WMEM_ADDR_BW)
    ) u_bank (
      .clk   (aclk),
      .rst_n (aresetn),
      .we    (bank_we[p]),
      .waddr (addr_cnt),
      .wdata (s_axis_tdata),
      .raddr (wmem_addr),
      .rdata (wmem_out[p*DW +: DW])
    );
  end

endmodule
